// File: rtl/acesso_memoria_pkg.sv
// Shared encodings for the data-memory access sequencer: load/store opcodes,
// sequencer states and the maximum supported read latency.
package acesso_memoria_pkg;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LB = 3'b001;
  localparam logic [2:0] OP_LH = 3'b010;
  localparam logic [2:0] OP_SH = 3'b011;
  localparam logic [2:0] OP_SB = 3'b100;
  localparam logic [2:0] OP_SW = 3'b101;

  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    ESCRITA,
    RESPOSTA
  } estado_t;

  function automatic logic op_invalido(input logic [2:0] op);
    return op > OP_SW;
  endfunction

  function automatic logic op_carga(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/acesso_memoria_dados_mesclador.sv
// Lane logic for the data-memory sequencer: store-word merge and load extension.
// Define ACESSO_MEMORIA_SINAL_EN to sign-extend LB/LH instead of zero-extending.
module mesclador_palavra
  import acesso_memoria_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] palavra,
  input  logic [31:0] dado_b,
  output logic [31:0] palavra_escrita,
  output logic [31:0] palavra_carga
);

  // Sub-word stores keep the untouched upper lanes of the word just read.
  always_comb begin
    palavra_escrita = dado_b;
    case (op)
      OP_SH:   palavra_escrita = {palavra[31:16], dado_b[15:0]};
      OP_SB:   palavra_escrita = {palavra[31:8], dado_b[7:0]};
      default: palavra_escrita = dado_b;
    endcase
  end

  always_comb begin
    palavra_carga = palavra;
    case (op)
`ifdef ACESSO_MEMORIA_SINAL_EN
      OP_LB:   palavra_carga = {{24{palavra[7]}}, palavra[7:0]};
      OP_LH:   palavra_carga = {{16{palavra[15]}}, palavra[15:0]};
`else
      OP_LB:   palavra_carga = {24'h0, palavra[7:0]};
      OP_LH:   palavra_carga = {16'h0, palavra[15:0]};
`endif
      default: palavra_carga = palavra;
    endcase
  end

endmodule

// File: rtl/acesso_memoria_dados.sv
// Load/store sequencer between the CPU datapath and a fixed-latency synchronous
// data memory. Optional macro ACESSO_MEMORIA_SINAL_EN selects signed LB/LH.
module acesso_memoria_dados
  import acesso_memoria_pkg::*;
#(
  parameter int LAT_LEITURA = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] endereco,
  input  logic [31:0] dado_escrita,
  output logic [31:0] dado_leitura,
  output logic        pronto,
  output logic        erro,
  output logic        ocupado,
  output logic [31:0] mem_endereco,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] CONT_INI = 4'(LAT_LEITURA - 1);

  estado_t     estado;
  estado_t     prox_estado;
  logic [2:0]  op_reg;
  logic [31:0] end_reg;
  logic [31:0] dado_reg;
  logic [31:0] palavra_reg;
  logic [3:0]  cont;
  logic        erro_reg;
  logic [31:0] palavra_mescla;
  logic [31:0] palavra_escrita;
  logic [31:0] palavra_carga;

  // Load extension works on the live memory word so the result is ready on entry
  // to RESPOSTA; the store merge uses the word captured at the end of LEITURA.
  assign palavra_mescla = (estado == LEITURA) ? mem_rdata : palavra_reg;

  mesclador_palavra u_mesclador (
    .op              (op_reg),
    .palavra         (palavra_mescla),
    .dado_b          (dado_reg),
    .palavra_escrita (palavra_escrita),
    .palavra_carga   (palavra_carga)
  );

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO: begin
        if (req) begin
          if (op_invalido(op))    prox_estado = RESPOSTA;
          else if (op == OP_SW)   prox_estado = ESCRITA;
          else                    prox_estado = LEITURA;
        end
      end
      LEITURA: begin
        if (cont == 4'd0) prox_estado = op_carga(op_reg) ? RESPOSTA : ESCRITA;
      end
      ESCRITA:  prox_estado = RESPOSTA;
      RESPOSTA: prox_estado = OCIOSO;
      default:  prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    mem_rd       = (estado == LEITURA);
    mem_wr       = (estado == ESCRITA);
    mem_endereco = (mem_rd || mem_wr) ? end_reg : 32'h0;
    mem_wdata    = mem_wr ? palavra_escrita : 32'h0;
    pronto       = (estado == RESPOSTA);
    erro         = pronto && erro_reg;
    ocupado      = (estado != OCIOSO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= OCIOSO;
      op_reg       <= 3'b000;
      end_reg      <= 32'h0;
      dado_reg     <= 32'h0;
      palavra_reg  <= 32'h0;
      cont         <= 4'd0;
      erro_reg     <= 1'b0;
      dado_leitura <= 32'h0;
    end else begin
      estado <= prox_estado;
      case (estado)
        OCIOSO: begin
          if (req) begin
            op_reg   <= op;
            end_reg  <= endereco;
            dado_reg <= dado_escrita;
            erro_reg <= op_invalido(op);
            cont     <= CONT_INI;
          end
        end
        LEITURA: begin
          if (cont == 4'd0) begin
            palavra_reg <= mem_rdata;
            if (op_carga(op_reg)) dado_leitura <= palavra_carga;
          end else begin
            cont <= cont - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acesso_memoria_dados.sv
// Scoreboard bench for acesso_memoria_dados against a word-array memory model.
// Honours ACESSO_MEMORIA_SINAL_EN in the reference model.
module tb_acesso_memoria_dados;
  import acesso_memoria_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] endereco = 32'h0;
  logic [31:0] dado_escrita = 32'h0;
  logic [31:0] dado_leitura;
  logic        pronto;
  logic        erro;
  logic        ocupado;
  logic [31:0] mem_endereco;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  acesso_memoria_dados #(.LAT_LEITURA(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .op           (op),
    .endereco     (endereco),
    .dado_escrita (dado_escrita),
    .dado_leitura (dado_leitura),
    .pronto       (pronto),
    .erro         (erro),
    .ocupado      (ocupado),
    .mem_endereco (mem_endereco),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    int          t_req;
    int          t_wr;
    int          t_pronto;
    logic [31:0] exp_load;
    logic        exp_err;
    logic        has_wr;
    logic [31:0] exp_wdata;
    int          exp_rd_cycles;
  } txn_t;

  txn_t        sb_q[$];
  txn_t        cur;
  bit          have;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          last_pronto = -10;
  bit          prev_hold = 1'b0;
  logic [31:0] dmem[0:255];
  logic [31:0] ref_mem[0:255];
  logic [31:0] ref_load = 32'h0;
  int          rd_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data is only trustworthy on the LAT-th consecutive read cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rd_run <= 0;
    else if (mem_rd) rd_run <= rd_run + 1;
    else             rd_run <= 0;
  end

  assign mem_rdata = (mem_rd && rd_run == LAT - 1) ? dmem[mem_endereco[9:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_wr) dmem[mem_endereco[9:2]] <= mem_wdata;
  end

  function automatic bit is_read(input logic [2:0] o);
    return o <= 3'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] got);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got 0x%08h, expected no such event (cycle %0d)", name, got, cyc);
  endtask

  // Builds the expected outcome from the instruction semantics and the reference
  // memory, then presents the request on an idle cycle.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input bit hold);
    txn_t t;
    int waited;
    logic [31:0] w;
    waited = 0;
    @(negedge clk);
    while (ocupado && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (ocupado) begin
      reportFail("idle_timeout", {31'h0, ocupado});
      return;
    end
    if (prev_hold) checkOutput("b2b_accept_cycle", 32'(cyc), 32'(last_pronto + 1));
    prev_hold = hold;

    w = ref_mem[a[9:2]];
    t.op = o;
    t.addr = a;
    t.t_req = cyc;
    t.t_wr = -1;
    t.exp_err = 1'b0;
    t.has_wr = 1'b0;
    t.exp_wdata = 32'h0;
    t.exp_rd_cycles = is_read(o) ? LAT : 0;
    case (o)
      OP_LW: ref_load = w;
      OP_LB: begin
        ref_load = w & 32'hFF;
`ifdef ACESSO_MEMORIA_SINAL_EN
        if (w[7]) ref_load = ref_load | 32'hFFFF_FF00;
`endif
      end
      OP_LH: begin
        ref_load = w & 32'hFFFF;
`ifdef ACESSO_MEMORIA_SINAL_EN
        if (w[15]) ref_load = ref_load | 32'hFFFF_0000;
`endif
      end
      OP_SB: t.exp_wdata = (w & 32'hFFFF_FF00) | (b & 32'hFF);
      OP_SH: t.exp_wdata = (w & 32'hFFFF_0000) | (b & 32'hFFFF);
      OP_SW: t.exp_wdata = b;
      default: t.exp_err = 1'b1;
    endcase
    t.exp_load = ref_load;
    if (o <= OP_LH) begin
      t.t_pronto = cyc + LAT + 1;
    end else if (o == OP_SH || o == OP_SB) begin
      t.has_wr = 1'b1;
      t.t_wr = cyc + LAT + 1;
      t.t_pronto = cyc + LAT + 2;
    end else if (o == OP_SW) begin
      t.has_wr = 1'b1;
      t.t_wr = cyc + 1;
      t.t_pronto = cyc + 2;
    end else begin
      t.t_pronto = cyc + 1;
    end
    if (t.has_wr) ref_mem[a[9:2]] = t.exp_wdata;
    sb_q.push_back(t);

    req = 1'b1;
    op = o;
    endereco = a;
    dado_escrita = b;
    @(posedge clk);
    #1;
    if (hold) begin
      op = 3'($urandom_range(0, 7));
      endereco = $urandom;
      dado_escrita = $urandom;
    end else begin
      req = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (reset_n) begin
      have = sb_q.size() > 0;
      if (have) cur = sb_q[0];
      if (mem_rd && mem_wr) reportFail("rd_wr_overlap", {30'h0, mem_rd, mem_wr});
      if (mem_rd) begin
        if (!have || !is_read(cur.op)) reportFail("unexpected_mem_rd", mem_endereco);
        else begin
          rd_cnt++;
          checkOutput("rd_addr", mem_endereco, cur.addr);
          checkOutput("rd_window", {31'h0, (cyc >= cur.t_req + 1) && (cyc <= cur.t_req + LAT)}, 32'h1);
        end
      end
      if (mem_wr) begin
        if (!have || !cur.has_wr) reportFail("unexpected_mem_wr", mem_wdata);
        else begin
          wr_cnt++;
          checkOutput("wr_addr", mem_endereco, cur.addr);
          checkOutput("wr_data", mem_wdata, cur.exp_wdata);
          checkOutput("wr_cycle", 32'(cyc), 32'(cur.t_wr));
        end
      end
      if (pronto) begin
        if (!have) reportFail("unexpected_pronto", dado_leitura);
        else begin
          checkOutput("pronto_cycle", 32'(cyc), 32'(cur.t_pronto));
          checkOutput("erro", {31'h0, erro}, {31'h0, cur.exp_err});
          checkOutput("dado_leitura", dado_leitura, cur.exp_load);
          checkOutput("rd_cycles", 32'(rd_cnt), 32'(cur.exp_rd_cycles));
          checkOutput("wr_cycles", 32'(wr_cnt), {31'h0, cur.has_wr});
          void'(sb_q.pop_front());
          last_pronto = cyc;
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end else begin
        if (erro) reportFail("erro_without_pronto", {31'h0, erro});
        if (have && cyc > cur.t_pronto + 5) begin
          reportFail("pronto_timeout", 32'(cyc));
          void'(sb_q.pop_front());
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_dado_leitura"}, dado_leitura, 32'h0);
    checkOutput({tag, "_mem_endereco"}, mem_endereco, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_flags"}, {27'h0, pronto, erro, ocupado, mem_rd, mem_wr}, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[i] = v;
    end
    dmem[16] = 32'h1234_5678; ref_mem[16] = 32'h1234_5678;
    dmem[32] = 32'hCAFE_F0A5; ref_mem[32] = 32'hCAFE_F0A5;
    dmem[48] = 32'hAABB_CCDD; ref_mem[48] = 32'hAABB_CCDD;
    dmem[49] = 32'hAABB_CCDD; ref_mem[49] = 32'hAABB_CCDD;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(OP_LW, 32'h40, 32'h0, 1'b0);
    applyStimulus(OP_LB, 32'h80, 32'h0, 1'b0);
    applyStimulus(OP_LH, 32'h80, 32'h0, 1'b0);
    applyStimulus(OP_SB, 32'hC0, 32'h0000_0011, 1'b0);
    applyStimulus(OP_SH, 32'hC4, 32'h9988_7766, 1'b0);
    applyStimulus(OP_SW, 32'hC8, 32'h0BAD_F00D, 1'b0);
    applyStimulus(3'b111, 32'h44, 32'h0, 1'b0);
    applyStimulus(3'b110, 32'h48, 32'h0, 1'b0);
    applyStimulus(OP_LW, 32'hC0, 32'h0, 1'b0);
    applyStimulus(OP_LW, 32'hC8, 32'h0, 1'b0);

    // Abort a read in flight: everything must clear at once and never complete.
    applyStimulus(OP_LW, 32'h40, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    sb_q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    ref_load = 32'h0;
    prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checkOutput("abort_dado_leitura", dado_leitura, 32'h0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom & 32'h3FF, $urandom,
                    1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    prev_hold = 1'b0;
    applyStimulus(OP_LW, 32'hC4, 32'h0, 1'b0);

    for (int k = 0; k < 200 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) reportFail("drain_timeout", 32'(sb_q.size()));
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
